five_sentense_1: RTL and testbench
==================================

FIVE_SENTENSE_1 -- requirements
Module: fiveSentense_1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameter THRESHOLD, default 3: the minimum number of asserted inputs for Y=1; legal range 1..5.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 Ports A, B, C, D, E, input, 1 bit each: the five votes (1 = yes).
REQ-006 Port Y, output, 1 bit: registered decision; 1 when the yes count is at least THRESHOLD.
REQ-007 Port vote_cnt, output, 3 bits: registered yes count, 0..5.
REQ-008 Port all_yes, output, 1 bit: registered; 1 when A..E are all 1.
REQ-009 Port all_no, output, 1 bit: registered; 1 when A..E are all 0.
REQ-010 Port y_rise, output, 1 bit: one-cycle pulse on a registered Y transition from 0 to 1.

Function
REQ-011 A..E SHALL be sampled on every rising clk edge and treated as synchronous to clk; the block contains no input synchronizer.
REQ-012 vote_cnt SHALL equal A+B+C+D+E of the sampled inputs, computed in 3-bit unsigned arithmetic with no overflow (maximum 5).
REQ-013 Y SHALL be 1 exactly when the sampled count is at least THRESHOLD; with the default, Y is the 5-input majority function.
REQ-014 all_yes SHALL be 1 exactly when count=5, and all_no exactly when count=0; the two are never 1 together.
REQ-015 Latency: an input change present before edge k SHALL appear on Y, vote_cnt, all_yes and all_no after edge k, i.e. exactly 1 cycle.
REQ-016 y_rise SHALL be 1 for exactly the one cycle in which Y changes from 0 to 1, and 0 otherwise, including while Y stays 1.
REQ-017 Y falling from 1 to 0 SHALL NOT produce any pulse.
REQ-018 Several inputs toggling in the same cycle SHALL be evaluated together as a single sample, with no intermediate result visible.
REQ-019 The decision SHALL depend only on the count, so every permutation of inputs with the same count gives an identical Y.

Reset
REQ-020 While rst_n=0 at a rising edge, the block SHALL set Y=0, vote_cnt=0, all_yes=0, all_no=0 and y_rise=0.
REQ-021 all_no SHALL be 0 during reset even though the reset value of vote_cnt is 0; this reset value overrides REQ-014.
REQ-022 On the first edge with rst_n=1, the outputs SHALL reflect the inputs sampled at that edge.
REQ-023 If that first sample gives Y=1, y_rise SHALL pulse, because Y was 0 during reset.
REQ-024 Reset asserted mid-operation SHALL clear all outputs at the next edge, and any pending y_rise is lost.

Structure
REQ-025 A shared package SHALL hold N_VOTES=5, CNT_W=3 and the default THRESHOLD=3.
REQ-026 One combinational sub-module, popcount5 (5-bit in, 3-bit count out), SHALL compute the count.
REQ-027 The top level SHALL hold the registers, the threshold compare and the edge detect.
REQ-028 There SHALL be no latches and no combinational path from an input to any output.

Verification
REQ-029 Hold rst_n=0 with A..E=11111 -> all outputs 0; release rst_n -> next cycle Y=1, vote_cnt=5, all_yes=1, y_rise=1; the following cycle y_rise=0.
REQ-030 Sweep all 32 input combinations, one per cycle -> each cycle Y=(count>=3) and vote_cnt=count, one cycle late.
REQ-031 Drive 00011 then 00111 -> Y goes 0 to 1 with a one-cycle y_rise pulse; then drive 00011 -> Y=0 and y_rise stays 0.
REQ-032 Toggle A with period 3, B 5, C 7, D 11 and E 13 time units (asynchronous to clk) -> every registered output matches the golden majority of the inputs sampled at the preceding edge.
REQ-033 Assert rst_n=0 for one cycle while Y=1 -> all outputs 0 that cycle; with inputs unchanged, on release Y=1 and y_rise=1.
REQ-034 Instantiate with THRESHOLD=5 and drive 11110 then 11111 -> Y is 0 then 1, and all_yes equals Y.

Source files
------------

// File: rtl/five_sentense_1_pkg.sv
// rtl/five_sentense_1_pkg.sv - shared constants for the five-input vote block
package five_sentense_1_pkg;

    localparam int N_VOTES           = 5;
    localparam int CNT_W             = 3;
    localparam int THRESHOLD_DEFAULT = 3;

endpackage

// File: rtl/five_sentense_1_popcount5.sv
// rtl/five_sentense_1_popcount5.sv - combinational yes-count of the five votes
module popcount5
    import five_sentense_1_pkg::*;
(
    input  logic [N_VOTES-1:0] votes,
    output logic [CNT_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_VOTES; i++) begin
            count = count + CNT_W'(votes[i]);
        end
    end

endmodule

// File: rtl/five_sentense_1.sv
// rtl/five_sentense_1.sv - registered threshold vote with count, unanimity flags and rise pulse
module five_sentense_1
    import five_sentense_1_pkg::*;
#(
    parameter int THRESHOLD = THRESHOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    output logic             Y,
    output logic [CNT_W-1:0] vote_cnt,
    output logic             all_yes,
    output logic             all_no,
    output logic             y_rise
);

    logic [CNT_W-1:0] cnt;
    logic             y_next;

    popcount5 u_popcount5 (
        .votes ({A, B, C, D, E}),
        .count (cnt)
    );

    assign y_next = (cnt >= CNT_W'(THRESHOLD));

    // y_rise compares the new decision with the registered one, so a reset
    // (Y forced to 0) followed by a yes-majority yields a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y        <= 1'b0;
            vote_cnt <= '0;
            all_yes  <= 1'b0;
            all_no   <= 1'b0;
            y_rise   <= 1'b0;
        end else begin
            Y        <= y_next;
            vote_cnt <= cnt;
            all_yes  <= (cnt == CNT_W'(N_VOTES));
            all_no   <= (cnt == '0);
            y_rise   <= y_next & ~Y;
        end
    end

endmodule

// File: tb/tb_five_sentense_1.sv
// tb/tb_five_sentense_1.sv - table-driven self-checking bench for five_sentense_1
module tb_five_sentense_1;

    typedef struct {
        logic       rst_n;
        logic [4:0] in;
        logic       y;
        logic [2:0] cnt;
        logic       ay;
        logic       an;
        logic       rise;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       A, B, C, D, E;
    logic       Y, all_yes, all_no, y_rise;
    logic [2:0] vote_cnt;
    logic       Y5, all_yes5, all_no5, y_rise5;
    logic [2:0] vote_cnt5;

    int n_cmp = 0;
    int n_err = 0;
    logic prev_y;

    five_sentense_1 dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E),
        .Y(Y), .vote_cnt(vote_cnt), .all_yes(all_yes), .all_no(all_no), .y_rise(y_rise)
    );

    five_sentense_1 #(.THRESHOLD(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E),
        .Y(Y5), .vote_cnt(vote_cnt5), .all_yes(all_yes5), .all_no(all_no5), .y_rise(y_rise5)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int idx, input logic ey, input logic [2:0] ec,
                            input logic eay, input logic ean, input logic er);
        chk({tag, ".Y"},        idx, {7'd0, Y},        {7'd0, ey});
        chk({tag, ".vote_cnt"}, idx, {5'd0, vote_cnt}, {5'd0, ec});
        chk({tag, ".all_yes"},  idx, {7'd0, all_yes},  {7'd0, eay});
        chk({tag, ".all_no"},   idx, {7'd0, all_no},   {7'd0, ean});
        chk({tag, ".y_rise"},   idx, {7'd0, y_rise},   {7'd0, er});
    endtask

    function automatic logic [2:0] ones(input logic [4:0] v);
        logic [2:0] n = 3'd0;
        for (int i = 0; i < 5; i++) n = n + {2'd0, v[i]};
        return n;
    endfunction

    task automatic drive(input logic r, input logic [4:0] v);
        @(negedge clk);
        rst_n = r;
        {A, B, C, D, E} = v;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [15];

    initial begin
        logic [2:0] c;
        logic       ey;
        logic [4:0] smp;

        rst_n = 1'b0;
        {A, B, C, D, E} = 5'b11111;
        prev_y = 1'b0;

        tbl[0]  = '{1'b0, 5'b11111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'b11111, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'b11111, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 5'b11111, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'b00011, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'b00111, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 5'b00111, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'b00011, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 5'b10101, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'b10101, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 5'b10101, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 5'b01011, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst_n, tbl[i].in);
            chk_main("tbl", i, tbl[i].y, tbl[i].cnt, tbl[i].ay, tbl[i].an, tbl[i].rise);
            prev_y = tbl[i].y;
        end

        // Exhaustive sweep, one combination per cycle, checked against a count model
        for (int v = 0; v < 32; v++) begin
            drive(1'b1, 5'(v));
            c  = ones(5'(v));
            ey = (c >= 3'd3);
            chk_main("sweep", v, ey, c, c == 3'd5, c == 3'd0, ey & ~prev_y);
            chk("sweep.Y5", v, {7'd0, Y5}, {7'd0, (c == 3'd5)});
            prev_y = ey;
        end

        // Inputs toggle on odd ticks, clock edges fall on even ticks
        fork
            begin
                for (int t = 0; t < 450; t++) begin
                    if (t % 3 == 0)  A = ~A;
                    if (t % 5 == 0)  B = ~B;
                    if (t % 7 == 0)  C = ~C;
                    if (t % 11 == 0) D = ~D;
                    if (t % 13 == 0) E = ~E;
                    #10;
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    smp = {A, B, C, D, E};
                    #1;
                    c  = ones(smp);
                    ey = (c >= 3'd3);
                    chk_main("async", k, ey, c, c == 3'd5, c == 3'd0, ey & ~prev_y);
                    prev_y = ey;
                end
            end
        join

        drive(1'b1, 5'b11110);
        chk("t5.Y5",        0, {7'd0, Y5},        8'd0);
        chk("t5.all_yes5",  0, {7'd0, all_yes5},  {7'd0, Y5});
        chk("t5.vote_cnt5", 0, {5'd0, vote_cnt5}, 8'd4);
        chk("t5.y_rise5",   0, {7'd0, y_rise5},   8'd0);
        chk("t5.all_no5",   0, {7'd0, all_no5},   8'd0);
        drive(1'b1, 5'b11111);
        chk("t5.Y5",        1, {7'd0, Y5},        8'd1);
        chk("t5.all_yes5",  1, {7'd0, all_yes5},  {7'd0, Y5});
        chk("t5.vote_cnt5", 1, {5'd0, vote_cnt5}, 8'd5);
        chk("t5.y_rise5",   1, {7'd0, y_rise5},   8'd1);
        chk("t5.all_no5",   1, {7'd0, all_no5},   8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
